// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI control FSM.
package spi_pkg;

    localparam int unsigned DefAddrBits = 7;
    localparam int unsigned DefDataBits = 8;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } spi_state_e;

    // Wide enough to hold the longer of the two phases without wrapping.
    function automatic int unsigned cnt_width(input int unsigned addr_bits,
                                              input int unsigned data_bits);
        int unsigned longest;
        longest = (addr_bits + 1 > data_bits) ? addr_bits + 1 : data_bits;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Phase bit counter with synchronous clear and a terminal-count strobe against a runtime limit.
module spi_bit_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [Width-1:0] limit,
    output logic             done
);

    logic [Width-1:0] count_q;

    // Fires on the increment that would reach the limit.
    assign done = inc && (count_q == limit - Width'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + Width'(1);
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI peripheral control FSM: sequences address, R/W and data phases of a frame.
// Optional abortFlag output enabled by defining SPI_FSM_ABORT_FLAG_EN.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int unsigned addrBits = DefAddrBits,
    parameter int unsigned dataBits = DefDataBits
) (
    input  logic clk,
    input  logic reset,
    input  logic chipSelect,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic addrWe,
    output logic dmWe,
    output logic srLoad,
    output logic misoBufe
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    output logic abortFlag
`endif
);

    localparam int unsigned CntW = cnt_width(addrBits, dataBits);
    localparam logic [CntW-1:0] AddrLimit = CntW'(addrBits + 1);
    localparam logic [CntW-1:0] DataLimit = CntW'(dataBits);

    spi_state_e state_q, state_d;

    logic            cnt_clear;
    logic            cnt_inc;
    logic            cnt_done;
    logic [CntW-1:0] cnt_limit;

    // Only the strobe that matters for the current phase is counted.
    always_comb begin
        cnt_inc   = 1'b0;
        cnt_limit = DataLimit;
        case (state_q)
            GET_ADDR: begin
                cnt_inc   = sclkPosEdge;
                cnt_limit = AddrLimit;
            end
            WRITE_GET:  cnt_inc = sclkPosEdge;
            READ_SHIFT: cnt_inc = sclkNegEdge;
            default:    cnt_inc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (!chipSelect) state_d = GET_ADDR;
            GET_ADDR:    if (cnt_done) state_d = GOT_ADDR;
            GOT_ADDR:    state_d = rwBit ? READ_LOAD : WRITE_GET;
            READ_LOAD:   state_d = READ_SHIFT;
            READ_SHIFT:  if (cnt_done) state_d = DONE;
            WRITE_GET:   if (cnt_done) state_d = WRITE_STORE;
            WRITE_STORE: state_d = DONE;
            DONE:        state_d = DONE;
            default:     state_d = IDLE;
        endcase
        // Deasserted chip select overrides every other transition.
        if (state_q != IDLE && chipSelect) begin
            state_d = IDLE;
        end
    end

    assign cnt_clear = (state_d != state_q) || (state_q == IDLE);

    spi_bit_counter #(
        .Width (CntW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .done  (cnt_done)
    );

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addrWe   <= 1'b0;
            dmWe     <= 1'b0;
            srLoad   <= 1'b0;
            misoBufe <= 1'b0;
        end else begin
            state_q  <= state_d;
            addrWe   <= (state_d == GOT_ADDR);
            dmWe     <= (state_d == WRITE_STORE);
            srLoad   <= (state_d == READ_LOAD);
            misoBufe <= (state_d == READ_SHIFT);
        end
    end

`ifdef SPI_FSM_ABORT_FLAG_EN
    // Leaving DONE is a normal frame end, not an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abortFlag <= 1'b0;
        end else begin
            abortFlag <= chipSelect && (state_q != IDLE) && (state_q != DONE);
        end
    end
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Directed self-checking bench for spi_fsm (abortFlag checks when SPI_FSM_ABORT_FLAG_EN is defined).
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset;
    logic chipSelect;
    logic sclkPosEdge;
    logic sclkNegEdge;
    logic rwBit;
    logic addrWe;
    logic dmWe;
    logic srLoad;
    logic misoBufe;
`ifdef SPI_FSM_ABORT_FLAG_EN
    logic abortFlag;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_addr = 0;
    int cnt_dm   = 0;
    int cnt_sr   = 0;
    int cnt_act  = 0;
    int cnt_abt  = 0;

    spi_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .chipSelect  (chipSelect),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .rwBit       (rwBit),
        .addrWe      (addrWe),
        .dmWe        (dmWe),
        .srLoad      (srLoad),
        .misoBufe    (misoBufe)
`ifdef SPI_FSM_ABORT_FLAG_EN
        ,
        .abortFlag   (abortFlag)
`endif
    );

    always #5 clk = ~clk;

    // Count high cycles of each output, sampled mid-cycle.
    always @(negedge clk) begin
        if (addrWe) cnt_addr++;
        if (dmWe) cnt_dm++;
        if (srLoad) cnt_sr++;
        if (addrWe || dmWe || srLoad || misoBufe) cnt_act++;
`ifdef SPI_FSM_ABORT_FLAG_EN
        if (abortFlag) cnt_abt++;
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic p, input logic n);
        sclkPosEdge = p;
        sclkNegEdge = n;
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr_we"}, {31'd0, addrWe}, 32'd0);
        check({tag, "_dm_we"}, {31'd0, dmWe}, 32'd0);
        check({tag, "_sr_load"}, {31'd0, srLoad}, 32'd0);
        check({tag, "_miso_bufe"}, {31'd0, misoBufe}, 32'd0);
    endtask

    // Leaves the FSM one clk past GOT_ADDR.
    task automatic send_addr(input logic [6:0] a, input logic rw);
        logic [7:0] w;
        w = {a, rw};
        chipSelect = 1'b0;
        tick();
        strobe(1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            rwBit = w[7-i];
            strobe(1'b1, 1'b0);
            if (i == 6) check("addr_we_early", {31'd0, addrWe}, 32'd0);
            if (i == 7) check("addr_we_pulse", {31'd0, addrWe}, 32'd1);
            tick();
        end
        check("addr_we_width", {31'd0, addrWe}, 32'd0);
    endtask

    task automatic write_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                strobe(1'b0, 1'b1);
                tick();
            end
            rwBit = d[7-i];
            strobe(1'b1, 1'b0);
            if (i == 6) check("dm_we_early", {31'd0, dmWe}, 32'd0);
            if (i == 7) check("dm_we_pulse", {31'd0, dmWe}, 32'd1);
            tick();
        end
        check("dm_we_width", {31'd0, dmWe}, 32'd0);
        check("write_sr_load", {31'd0, srLoad}, 32'd0);
        check("write_miso", {31'd0, misoBufe}, 32'd0);
    endtask

    task automatic read_data(input int n);
        check("sr_load_pulse", {31'd0, srLoad}, 32'd1);
        tick();
        check("sr_load_width", {31'd0, srLoad}, 32'd0);
        check("miso_on", {31'd0, misoBufe}, 32'd1);
        strobe(1'b1, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            strobe(i == 0, 1'b1);
            if (n == 8 && i == 6) check("miso_held", {31'd0, misoBufe}, 32'd1);
            if (n == 8 && i == 7) check("miso_off", {31'd0, misoBufe}, 32'd0);
            tick();
        end
    endtask

    int a0, d0, s0, b0;

    initial begin
        reset       = 1'b1;
        chipSelect  = 1'b1;
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        rwBit       = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        // Write frame: 7'h2A, data 8'hC3.
        s0 = cnt_sr;
        send_addr(7'h2A, 1'b0);
        write_data(8'hC3);
        check("write_no_sr_load", cnt_sr - s0, 0);

        // DONE hold: extra strobes with CS still low.
        b0 = cnt_abt;
        tick();
        a0 = cnt_act;
        for (int i = 0; i < 5; i++) begin
            strobe(1'b1, 1'b0);
            tick();
            strobe(1'b0, 1'b1);
            tick();
        end
        tick();
        check("done_hold_activity", cnt_act - a0, 0);
        chipSelect = 1'b1;
        tick();
        tick();
        check_all_zero("done_exit");
        check("done_exit_abort", cnt_abt - b0, 0);

        // Read frame: 7'h05.
        send_addr(7'h05, 1'b1);
        read_data(8);
        check_all_zero("read_done");
        chipSelect = 1'b1;
        tick();

        // Write abort after 4 data bits.
        d0 = cnt_dm;
        b0 = cnt_abt;
        send_addr(7'h33, 1'b0);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 1'b0);
            tick();
        end
        chipSelect = 1'b1;
        tick();
`ifdef SPI_FSM_ABORT_FLAG_EN
        check("abort_flag_pulse", {31'd0, abortFlag}, 32'd1);
`endif
        check_all_zero("abort");
        tick();
`ifdef SPI_FSM_ABORT_FLAG_EN
        check("abort_flag_width", {31'd0, abortFlag}, 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            strobe(1'b1, 1'b0);
            tick();
        end
        check("abort_no_dm_we", cnt_dm - d0, 0);
`ifdef SPI_FSM_ABORT_FLAG_EN
        check("abort_flag_count", cnt_abt - b0, 1);
`endif

        // Async reset mid READ_SHIFT after 3 negedges.
        send_addr(7'h05, 1'b1);
        read_data(3);
        check("pre_reset_miso", {31'd0, misoBufe}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #2;
        reset      = 1'b0;
        chipSelect = 1'b1;
        tick();
        send_addr(7'h2A, 1'b0);
        write_data(8'h5A);
        chipSelect = 1'b1;
        tick();

        // Back-to-back write then read of 7'h01.
        tick();
        a0 = cnt_addr;
        d0 = cnt_dm;
        s0 = cnt_sr;
        send_addr(7'h01, 1'b0);
        write_data(8'h11);
        chipSelect = 1'b1;
        tick();
        send_addr(7'h01, 1'b1);
        read_data(8);
        chipSelect = 1'b1;
        tick();
        tick();
        check("b2b_addr_we", cnt_addr - a0, 2);
        check("b2b_dm_we", cnt_dm - d0, 1);
        check("b2b_sr_load", cnt_sr - s0, 1);
        check_all_zero("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
